// File: rtl/apb_exe_unit_2.sv
// APB slave wrapping a multi-cycle add/sub/mul/xor unit with operand, control, result and status registers.
// Optional build macro APB_EXE_IRQ_EN adds o_irq (set on completion, cleared by a STATUS read, mirrored in STATUS[3]).
module apb_exe_unit_2 #(
    parameter int SEL_WIDTH  = 3,
    parameter int SEL_BIT    = 1,
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 32,
    parameter int ARG_WIDTH  = 16
) (
    input  logic                  i_PCLK,
    input  logic                  i_PRESETn,
    input  logic [SEL_WIDTH-1:0]  i_PSEL,
    input  logic                  i_PENABLE,
    input  logic                  i_PWRITE,
    input  logic [ADDR_WIDTH-1:0] i_PADDR,
    input  logic [DATA_WIDTH-1:0] i_PWDATA,
    output logic                  o_PREADY,
    output logic                  o_PSLVERR,
    output logic [DATA_WIDTH-1:0] o_PRDATA
`ifdef APB_EXE_IRQ_EN
    ,
    output logic                  o_irq
`endif
);

    localparam int RW = 2 * ARG_WIDTH;
    localparam int CW = $clog2(ARG_WIDTH + 1);

    localparam logic [ADDR_WIDTH-1:0] A_ARG_A  = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] A_ARG_B  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] A_CTRL   = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] A_RESULT = ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] A_STATUS = ADDR_WIDTH'(4);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [ARG_WIDTH-1:0]    arg_a_q, arg_a_d, arg_b_q, arg_b_d;
    logic [1:0]              op_q, op_d;
    logic [RW-1:0]           mcand_q, mcand_d, acc_q, acc_d, result_q, result_d;
    logic [ARG_WIDTH-1:0]    mplier_q, mplier_d;
    logic [CW-1:0]           count_q, count_d;
    logic                    carry_q, carry_d, irq_q, irq_d;
    logic                    pready_q, pready_d, pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;

    logic                    access, busy, irq_bit;
    logic [3:0]              status;
    logic [ARG_WIDTH:0]      alu_res;
    logic [RW-1:0]           acc_next;
    logic                    unused_ok;

    assign access = i_PSEL[SEL_BIT-1] & i_PENABLE & ~pready_q;
    assign busy   = (state_q == S_CALC);

`ifdef APB_EXE_IRQ_EN
    assign irq_bit = irq_q;
    assign o_irq   = irq_q;
    assign unused_ok = ^{i_PWDATA[DATA_WIDTH-1:ARG_WIDTH], i_PSEL};
`else
    assign irq_bit = 1'b0;
    assign unused_ok = ^{i_PWDATA[DATA_WIDTH-1:ARG_WIDTH], i_PSEL, irq_q};
`endif

    assign status = {irq_bit, carry_q, (state_q == S_DONE), busy};

    always_comb begin
        state_d   = state_q;
        arg_a_d   = arg_a_q;
        arg_b_d   = arg_b_q;
        op_d      = op_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        count_d   = count_q;
        result_d  = result_q;
        carry_d   = carry_q;
        irq_d     = irq_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;
        alu_res   = '0;
        acc_next  = acc_q;

        // A RESULT read during CALC is held off (no response) until the unit reaches DONE.
        if (access && !(!i_PWRITE && i_PADDR == A_RESULT && busy)) begin
            pready_d = 1'b1;
            if (i_PWRITE) begin
                case (i_PADDR)
                    A_ARG_A, A_ARG_B: begin
                        if (busy) begin
                            pslverr_d = 1'b1;
                        end else begin
                            if (i_PADDR == A_ARG_A) arg_a_d = i_PWDATA[ARG_WIDTH-1:0];
                            else                    arg_b_d = i_PWDATA[ARG_WIDTH-1:0];
                            if (state_q == S_DONE) state_d = S_IDLE;
                        end
                    end
                    A_CTRL: begin
                        if (busy) begin
                            pslverr_d = 1'b1;
                        end else begin
                            op_d = i_PWDATA[1:0];
                            if (i_PWDATA[2]) begin
                                state_d  = S_CALC;
                                mcand_d  = RW'(arg_a_q);
                                mplier_d = arg_b_q;
                                acc_d    = '0;
                                count_d  = (i_PWDATA[1:0] == OP_MUL) ? CW'(ARG_WIDTH - 1) : '0;
                            end
                        end
                    end
                    default: pslverr_d = 1'b1;
                endcase
            end else begin
                case (i_PADDR)
                    A_ARG_A:  prdata_d = DATA_WIDTH'(arg_a_q);
                    A_ARG_B:  prdata_d = DATA_WIDTH'(arg_b_q);
                    A_CTRL:   prdata_d = '0;
                    A_RESULT: prdata_d = DATA_WIDTH'(result_q);
                    A_STATUS: begin
                        prdata_d = DATA_WIDTH'(status);
                        irq_d    = 1'b0;
                    end
                    default:  pslverr_d = 1'b1;
                endcase
            end
        end

        // Datapath works only on the operands latched at start; completion sets irq after any clear above.
        if (busy) begin
            case (op_q)
                OP_ADD:  alu_res = {1'b0, mcand_q[ARG_WIDTH-1:0]} + {1'b0, mplier_q};
                OP_SUB:  alu_res = {1'b0, mcand_q[ARG_WIDTH-1:0]} - {1'b0, mplier_q};
                OP_XOR:  alu_res = {1'b0, mcand_q[ARG_WIDTH-1:0] ^ mplier_q};
                default: alu_res = '0;
            endcase
            acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
            if (op_q == OP_MUL) begin
                acc_d    = acc_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
            end
            if (count_q == '0) begin
                state_d = S_DONE;
                irq_d   = 1'b1;
                if (op_q == OP_MUL) begin
                    result_d = acc_next;
                    carry_d  = 1'b0;
                end else begin
                    result_d = RW'(alu_res[ARG_WIDTH-1:0]);
                    carry_d  = (op_q != OP_XOR) & alu_res[ARG_WIDTH];
                end
            end else begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
        if (!i_PRESETn) begin
            state_q   <= S_IDLE;
            arg_a_q   <= '0;
            arg_b_q   <= '0;
            op_q      <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            count_q   <= '0;
            result_q  <= '0;
            carry_q   <= 1'b0;
            irq_q     <= 1'b0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            arg_a_q   <= arg_a_d;
            arg_b_q   <= arg_b_d;
            op_q      <= op_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
            result_q  <= result_d;
            carry_q   <= carry_d;
            irq_q     <= irq_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
        end
    end

    assign o_PREADY  = pready_q;
    assign o_PSLVERR = pslverr_q;
    assign o_PRDATA  = prdata_q;

endmodule

// File: tb/tb_apb_exe_unit_2.sv
// Directed bench for apb_exe_unit_2: a register-access vector table plus hand-written multi-cycle sequences.
// Handshake: a transfer completes in the cycle where o_PREADY=1; o_PSLVERR/o_PRDATA are only meaningful then.
module tb_apb_exe_unit_2;

    logic        clk;
    logic        rst_n;
    logic [2:0]  psel;
    logic        penable;
    logic        pwrite;
    logic [2:0]  paddr;
    logic [31:0] pwdata;
    logic        pready;
    logic        pslverr;
    logic [31:0] prdata;
`ifdef APB_EXE_IRQ_EN
    logic        irq;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        wr;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] exp_q[$];

    apb_exe_unit_2 dut (
        .i_PCLK    (clk),
        .i_PRESETn (rst_n),
        .i_PSEL    (psel),
        .i_PENABLE (penable),
        .i_PWRITE  (pwrite),
        .i_PADDR   (paddr),
        .i_PWDATA  (pwdata),
        .o_PREADY  (pready),
        .o_PSLVERR (pslverr),
        .o_PRDATA  (prdata)
`ifdef APB_EXE_IRQ_EN
        ,
        .o_irq     (irq)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bus_idle();
        psel    = 3'b000;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
    endtask

    // driver: setup phase, access phase, then wait (bounded) for o_PREADY
    task automatic apb_xfer(input logic wr, input logic [2:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output logic err, output int waits);
        bit got;
        got   = 1'b0;
        waits = 0;
        rdata = '0;
        err   = 1'b0;
        @(posedge clk); #1;
        psel    = 3'b001;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = wdata;
        @(posedge clk); #1;
        penable = 1'b1;
        for (int i = 0; i < 60 && !got; i++) begin
            @(posedge clk); #1;
            if (pready) begin
                got   = 1'b1;
                rdata = prdata;
                err   = pslverr;
            end else begin
                waits++;
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL xfer_timeout: addr %0d no PREADY after %0d cycles", addr, waits);
        end
        bus_idle();
    endtask

    task automatic do_wr(input string name, input logic [2:0] addr, input logic [31:0] wdata, input logic exp_err);
        logic [31:0] d;
        logic e;
        int w;
        apb_xfer(1'b1, addr, wdata, d, e, w);
        check({name, "_err"}, {31'b0, e}, {31'b0, exp_err});
    endtask

    task automatic do_rd(input string name, input logic [2:0] addr, input logic [31:0] exp_data, input logic exp_err);
        logic [31:0] d;
        logic e;
        int w;
        apb_xfer(1'b0, addr, 32'h0, d, e, w);
        check({name, "_data"}, d, exp_data);
        check({name, "_err"}, {31'b0, e}, {31'b0, exp_err});
    endtask

    task automatic wait_done(input string name);
        logic [31:0] d;
        logic e;
        int w;
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            apb_xfer(1'b0, 3'd4, 32'h0, d, e, w);
            if (d[1]) seen = 1'b1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s: done never seen, last status 0x%08h expected done=1", name, d);
        end
    endtask

    initial begin
        logic [31:0] d;
        logic        e;
        int          w;
        int          stray;

        bus_idle();
        rst_n = 1'b0;

        // register-access table
        vecs.push_back('{1'b1, 3'd0, 32'h0000_1234, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 3'd0, 32'h0,         32'h0000_1234, 1'b0});
        vecs.push_back('{1'b1, 3'd0, 32'hABCD_5678, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 3'd0, 32'h0,         32'h0000_5678, 1'b0});
        vecs.push_back('{1'b1, 3'd1, 32'hFFFF_0009, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 3'd1, 32'h0,         32'h0000_0009, 1'b0});
        vecs.push_back('{1'b0, 3'd2, 32'h0,         32'h0, 1'b0});
        vecs.push_back('{1'b1, 3'd3, 32'h1111_1111, 32'h0, 1'b1});
        vecs.push_back('{1'b1, 3'd4, 32'h0000_0007, 32'h0, 1'b1});
        vecs.push_back('{1'b0, 3'd5, 32'h0,         32'h0, 1'b1});
        vecs.push_back('{1'b0, 3'd7, 32'h0,         32'h0, 1'b1});
        vecs.push_back('{1'b1, 3'd6, 32'h0000_0001, 32'h0, 1'b1});
        vecs.push_back('{1'b0, 3'd4, 32'h0,         32'h0, 1'b0});
        // xor 0x00F0 ^ 0x0FF0 = 0x0F00
        vecs.push_back('{1'b1, 3'd0, 32'h0000_00F0, 32'h0, 1'b0});
        vecs.push_back('{1'b1, 3'd1, 32'h0000_0FF0, 32'h0, 1'b0});
        vecs.push_back('{1'b1, 3'd2, 32'h0000_0007, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 3'd4, 32'h0,         32'h0000_0002, 1'b0});
        vecs.push_back('{1'b0, 3'd3, 32'h0,         32'h0000_0F00, 1'b0});
        // ARG write in DONE returns to IDLE, result kept
        vecs.push_back('{1'b1, 3'd0, 32'h0000_0007, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 3'd4, 32'h0,         32'h0, 1'b0});
        vecs.push_back('{1'b0, 3'd3, 32'h0,         32'h0000_0F00, 1'b0});
        // sub 7-5 = 2, no borrow; then CTRL with start=0 changes nothing
        vecs.push_back('{1'b1, 3'd1, 32'h0000_0005, 32'h0, 1'b0});
        vecs.push_back('{1'b1, 3'd2, 32'h0000_0005, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 3'd4, 32'h0,         32'h0000_0002, 1'b0});
        vecs.push_back('{1'b0, 3'd3, 32'h0,         32'h0000_0002, 1'b0});
        vecs.push_back('{1'b1, 3'd2, 32'h0000_0002, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 3'd4, 32'h0,         32'h0000_0002, 1'b0});
        vecs.push_back('{1'b0, 3'd3, 32'h0,         32'h0000_0002, 1'b0});

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_pready",  {31'b0, pready},  32'h0);
        check("rst_pslverr", {31'b0, pslverr}, 32'h0);
        check("rst_prdata",  prdata,           32'h0);
`ifdef APB_EXE_IRQ_EN
        check("rst_irq", {31'b0, irq}, 32'h0);
`endif
        rst_n = 1'b1;
        do_rd("rst_status", 3'd4, 32'h0, 1'b0);
        do_rd("rst_result", 3'd3, 32'h0, 1'b0);

        // table
        foreach (vecs[i]) begin
            exp_q.push_back(vecs[i].exp_data);
            apb_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, d, e, w);
            check($sformatf("vec%0d_data", i), d, exp_q.pop_front());
            check($sformatf("vec%0d_err", i), {31'b0, e}, {31'b0, vecs[i].exp_err});
        end

        // add with carry out: 0xFFFF + 1
        do_wr("add_a", 3'd0, 32'h0000_FFFF, 1'b0);
        do_wr("add_b", 3'd1, 32'h0000_0001, 1'b0);
        do_wr("add_go", 3'd2, 32'h0000_0004, 1'b0);
        wait_done("add_wait");
        do_rd("add_status", 3'd4, 32'h0000_0006, 1'b0);
        do_rd("add_result", 3'd3, 32'h0000_0000, 1'b0);

        // mul with immediate stalled RESULT read
        do_wr("mul_a", 3'd0, 32'h0000_1234, 1'b0);
        do_wr("mul_b", 3'd1, 32'h0000_0100, 1'b0);
        do_wr("mul_go", 3'd2, 32'h0000_0006, 1'b0);
        apb_xfer(1'b0, 3'd3, 32'h0, d, e, w);
        check("mul_result", d, 32'h0012_3400);
        check("mul_err", {31'b0, e}, 32'h0);
        total++;
        if (w < 8 || w > 20) begin
            bad++;
            $display("FAIL mul_stall: waited %0d cycles, required 8..20", w);
        end
        do_rd("mul_status", 3'd4, 32'h0000_0002, 1'b0);

        // illegal accesses while a mul is running
        do_wr("bz_a", 3'd0, 32'h0000_00FF, 1'b0);
        do_wr("bz_b", 3'd1, 32'h0000_0101, 1'b0);
        do_wr("bz_go", 3'd2, 32'h0000_0006, 1'b0);
        do_wr("bz_wr_a", 3'd0, 32'h0000_5555, 1'b1);
        do_rd("bz_rd_a", 3'd0, 32'h0000_00FF, 1'b0);
        do_rd("bz_rd6", 3'd6, 32'h0, 1'b1);
        do_rd("bz_status", 3'd4, 32'h0000_0001, 1'b0);
        do_wr("bz_ctrl", 3'd2, 32'h0000_0004, 1'b1);
        do_rd("bz_result", 3'd3, 32'h0000_FFFF, 1'b0);

        // abandoned stalled read: no response may appear afterwards
        do_wr("ab_go", 3'd2, 32'h0000_0006, 1'b0);
        @(posedge clk); #1;
        psel = 3'b001; pwrite = 1'b0; paddr = 3'd3;
        @(posedge clk); #1;
        penable = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus_idle();
        stray = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (pready) stray++;
        end
        check("ab_no_resp", stray, 32'h0);
        do_rd("ab_result", 3'd3, 32'h0000_FFFF, 1'b0);

        // reset mid-mul while a STATUS response is on the bus
        do_wr("rm_go", 3'd2, 32'h0000_0006, 1'b0);
        @(posedge clk); #1;
        psel = 3'b001; pwrite = 1'b0; paddr = 3'd4;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        check("rm_pre_pready", {31'b0, pready}, 32'h1);
        check("rm_pre_prdata", prdata, 32'h0000_0001);
        #2;
        rst_n = 1'b0;
        #1;
        check("rm_pready", {31'b0, pready}, 32'h0);
        check("rm_prdata", prdata, 32'h0);
        check("rm_pslverr", {31'b0, pslverr}, 32'h0);
        bus_idle();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_rd("rm_status", 3'd4, 32'h0, 1'b0);
        do_rd("rm_result", 3'd3, 32'h0, 1'b0);

`ifdef APB_EXE_IRQ_EN
        // sub with borrow raises irq; STATUS read clears it
        do_wr("irq_a", 3'd0, 32'h0000_0005, 1'b0);
        do_wr("irq_b", 3'd1, 32'h0000_0007, 1'b0);
        do_wr("irq_go", 3'd2, 32'h0000_0005, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("irq_set", {31'b0, irq}, 32'h1);
        do_rd("irq_result", 3'd3, 32'h0000_FFFE, 1'b0);
        do_rd("irq_status", 3'd4, 32'h0000_000E, 1'b0);
        #1;
        check("irq_clr", {31'b0, irq}, 32'h0);
        do_rd("irq_status2", 3'd4, 32'h0000_0006, 1'b0);
`else
        // sub with borrow, STATUS[3] stays 0
        do_wr("sb_a", 3'd0, 32'h0000_0005, 1'b0);
        do_wr("sb_b", 3'd1, 32'h0000_0007, 1'b0);
        do_wr("sb_go", 3'd2, 32'h0000_0005, 1'b0);
        do_rd("sb_result", 3'd3, 32'h0000_FFFE, 1'b0);
        do_rd("sb_status", 3'd4, 32'h0000_0006, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
